sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of SRAM-like master ports (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the in-flight ID FIFO (power of 2, 2..16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, data width; wstrb width is DATA_WIDTH/8.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports m_req/m_wr, input, NUM_MASTERS, per-master request and write flag; m_size, input, 2*NUM_MASTERS; m_wstrb, input, NUM_MASTERS*DATA_WIDTH/8; m_addr, input, NUM_MASTERS*ADDR_WIDTH; m_wdata, input, NUM_MASTERS*DATA_WIDTH; master i occupies slice i.
REQ-008 SHALL have ports m_addr_ok/m_data_ok, output, NUM_MASTERS, per-master handshakes; m_rdata, output, DATA_WIDTH, shared read data.
REQ-009 SHALL have ports s_req, s_wr, output, 1; s_size, output, 2; s_wstrb, output, DATA_WIDTH/8; s_addr, output, ADDR_WIDTH; s_wdata, output, DATA_WIDTH; s_addr_ok, s_data_ok, input, 1; s_rdata, input, DATA_WIDTH.
REQ-010 SHALL have port outstanding, output, clog2(MAX_OUTSTANDING+1), accepted requests awaiting data_ok.
REQ-011 SHALL have port err_orphan, output, 1, sticky flag: s_data_ok seen with no request in flight.

Function
REQ-012 Request accepted on a cycle with s_req=1 and s_addr_ok=1; response completes on a cycle with s_data_ok=1; slave returns responses in acceptance order.
REQ-013 Grant FSM states IDLE and LOCKED; reset state IDLE.
REQ-014 IDLE: grant = first master with m_req=1 searching from rr_ptr upward, wrapping NUM_MASTERS-1 -> 0; s_req=1 iff any m_req=1 and FIFO not full.
REQ-015 IDLE, s_req=1 and s_addr_ok=0: register granted index, go LOCKED; IDLE with acceptance: stay IDLE.
REQ-016 LOCKED: grant held on registered index regardless of other m_req; return to IDLE on acceptance; no re-arbitration until then.
REQ-017 s_wr/s_size/s_wstrb/s_addr/s_wdata SHALL be combinational mux of granted master's slice; 0 when s_req=0.
REQ-018 m_addr_ok[i] = s_addr_ok & s_req & (grant==i); all other bits 0.
REQ-019 On acceptance: push granted index into ID FIFO, rr_ptr <= (grant+1) mod NUM_MASTERS.
REQ-020 FIFO full (outstanding==MAX_OUTSTANDING): s_req=0, even if a pop occurs that cycle; a locked grant is retained.
REQ-021 On s_data_ok with FIFO non-empty: m_data_ok[head]=1 same cycle, pop head; m_rdata = s_rdata always (pass-through).
REQ-022 Simultaneous push and pop: outstanding unchanged, both pointers advance.
REQ-023 s_data_ok with FIFO empty: no m_data_ok, err_orphan <= 1 next cycle, held until reset.
REQ-024 Zero added latency: all handshake paths combinational; only FSM, rr_ptr, FIFO, count, err_orphan registered.
REQ-025 Pointers wrap modulo MAX_OUTSTANDING; count never exceeds MAX_OUTSTANDING nor goes below 0.

Reset
REQ-026 resetn=0 SHALL asynchronously set FSM IDLE, rr_ptr 0, FIFO pointers 0, outstanding 0, err_orphan 0.
REQ-027 While resetn=0, s_req, all m_addr_ok and m_data_ok SHALL be 0; in-flight responses are discarded (reset mid-operation flushes FIFO).
REQ-028 First arbitration after reset release starts at master 0.

Verification
REQ-029 NUM_MASTERS=2, m_req=2'b11, s_addr_ok=1 continuously, 4 cycles -> grants 0,1,0,1; outstanding 1,2,3,4.
REQ-030 Master1 alone, s_addr_ok=0 for 3 cycles, master0 raises req cycle 2 -> s_addr held 0x1000_0004 (master1), m_addr_ok=2'b10 on cycle 4, master0 granted cycle 5.
REQ-031 MAX_OUTSTANDING=4, 4 accepted, no data_ok -> s_req=0 despite m_req=1; one s_data_ok -> m_data_ok to oldest, s_req=1 next cycle.
REQ-032 Accept m0,m1; s_data_ok twice, s_rdata=0xDEAD_BEEF then 0x1234_5678 -> m_data_ok=01 with 0xDEAD_BEEF, then 10 with 0x1234_5678; outstanding 0.
REQ-033 s_data_ok with outstanding=0 -> no m_data_ok, err_orphan=1 until resetn=0.
REQ-034 resetn low with 3 outstanding -> outstanding=0, s_req=0 immediately; post-release grant to master 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter folding several SRAM-like masters onto one slave port,
// with an in-order ID FIFO steering data_ok back to the issuing master.
//
//   state     | meaning
//   ST_IDLE   | free to arbitrate; grant follows round-robin search from rr_ptr
//   ST_LOCKED | slave stalled addr_ok; grant pinned to lock_idx until accepted
module sram_like_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [NUM_MASTERS-1:0]                  m_req,
    input  logic [NUM_MASTERS-1:0]                  m_wr,
    input  logic [2*NUM_MASTERS-1:0]                m_size,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]   m_wstrb,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]       m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]       m_wdata,
    output logic [NUM_MASTERS-1:0]                  m_addr_ok,
    output logic [NUM_MASTERS-1:0]                  m_data_ok,
    output logic [DATA_WIDTH-1:0]                   m_rdata,
    output logic                                    s_req,
    output logic                                    s_wr,
    output logic [1:0]                              s_size,
    output logic [DATA_WIDTH/8-1:0]                 s_wstrb,
    output logic [ADDR_WIDTH-1:0]                   s_addr,
    output logic [DATA_WIDTH-1:0]                   s_wdata,
    input  logic                                    s_addr_ok,
    input  logic                                    s_data_ok,
    input  logic [DATA_WIDTH-1:0]                   s_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
    output logic                                    err_orphan
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] next_rr;
    logic             any_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [IDX_W-1:0] id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Scan downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin : p_arb
        int cand;
        cand    = 0;
        arb_idx = rr_ptr;
        any_req = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (m_req[cand]) begin
                arb_idx = IDX_W'(cand);
                any_req = 1'b1;
            end
        end
    end

    assign grant      = (state == ST_LOCKED) ? lock_idx : arb_idx;
    assign next_rr    = (grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant + IDX_W'(1);
    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);

    assign s_req = resetn & ~fifo_full & ((state == ST_LOCKED) | any_req);
    assign push  = s_req & s_addr_ok;
    assign pop   = resetn & s_data_ok & ~fifo_empty;

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (s_req) begin
            s_wr    = m_wr[grant];
            s_size  = m_size[2*grant +: 2];
            s_wstrb = m_wstrb[STRB_W*grant +: STRB_W];
            s_addr  = m_addr[ADDR_WIDTH*grant +: ADDR_WIDTH];
            s_wdata = m_wdata[DATA_WIDTH*grant +: DATA_WIDTH];
        end
    end

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (push) m_addr_ok[grant] = 1'b1;
        if (pop)  m_data_ok[id_mem[rd_ptr]] = 1'b1;
    end

    assign m_rdata     = s_rdata;
    assign outstanding = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_req && !s_addr_ok) begin
                        state    <= ST_LOCKED;
                        lock_idx <= arb_idx;
                    end
                end
                ST_LOCKED: begin
                    if (push) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (push) rr_ptr <= next_rr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (s_data_ok && fifo_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter; a queue of expected master IDs is
// filled on each acceptance and drained against m_data_ok on each response.
module tb_sram_like_arbiter;

    localparam int NM = 2;
    localparam int MO = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [NM-1:0]      m_req = '0;
    logic [NM-1:0]      m_wr;
    logic [2*NM-1:0]    m_size;
    logic [NM*DW/8-1:0] m_wstrb;
    logic [NM*AW-1:0]   m_addr;
    logic [NM*DW-1:0]   m_wdata;
    logic [NM-1:0]      m_addr_ok;
    logic [NM-1:0]      m_data_ok;
    logic [DW-1:0]      m_rdata;
    logic               s_req;
    logic               s_wr;
    logic [1:0]         s_size;
    logic [DW/8-1:0]    s_wstrb;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_wdata;
    logic               s_addr_ok = 1'b0;
    logic               s_data_ok = 1'b0;
    logic [DW-1:0]      s_rdata = '0;
    logic [$clog2(MO+1)-1:0] outstanding;
    logic               err_orphan;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    sram_like_arbiter #(
        .NUM_MASTERS(NM), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] addr_of(input int idx);
        return (idx == 1) ? 32'h1000_0004 : 32'h1000_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic accept(input string tag, input int idx);
        s_addr_ok = 1'b1;
        settle();
        chk({tag, "_addr_ok"}, m_addr_ok, 64'd1 << idx);
        chk({tag, "_s_addr"}, s_addr, addr_of(idx));
        exp_q.push_back(idx);
        tick();
        s_addr_ok = 1'b0;
    endtask

    task automatic respond(input string tag, input logic [31:0] rd);
        int id;
        s_data_ok = 1'b1;
        s_rdata   = rd;
        settle();
        id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk({tag, "_data_ok"}, m_data_ok, (id < 0) ? 64'd0 : (64'd1 << id));
        chk({tag, "_rdata"}, m_rdata, rd);
        tick();
        s_data_ok = 1'b0;
    endtask

    initial begin
        m_wr    = 2'b10;
        m_size  = {2'd2, 2'd1};
        m_wstrb = {4'hF, 4'h3};
        m_addr  = {32'h1000_0004, 32'h1000_0000};
        m_wdata = {32'hB1B1_1111, 32'hA0A0_0000};

        // Reset is dominant over pending requests and stray responses.
        m_req     = 2'b11;
        s_data_ok = 1'b1;
        #3;
        chk("rst_s_req", s_req, 0);
        chk("rst_m_addr_ok", m_addr_ok, 0);
        chk("rst_m_data_ok", m_data_ok, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_s_addr", s_addr, 0);
        s_data_ok = 1'b0;
        tick();
        resetn = 1'b1;

        // Round-robin with both masters requesting.
        for (int i = 0; i < 4; i++) begin
            accept("rr", i % 2);
            chk("rr_outstanding", outstanding, i + 1);
        end
        s_addr_ok = 1'b1;
        settle();
        chk("full_s_req", s_req, 0);
        chk("full_m_addr_ok", m_addr_ok, 0);
        chk("full_s_addr", s_addr, 0);
        tick();

        // Pop while full: still no request this cycle, request returns next.
        s_data_ok = 1'b1;
        s_rdata   = 32'hCAFE_0001;
        settle();
        chk("full_pop_s_req", s_req, 0);
        chk("full_pop_m_addr_ok", m_addr_ok, 0);
        chk("full_pop_data_ok", m_data_ok, 64'd1 << exp_q.pop_front());
        chk("full_pop_rdata", m_rdata, 32'hCAFE_0001);
        tick();
        s_data_ok = 1'b0;
        s_addr_ok = 1'b0;
        chk("after_pop_s_req", s_req, 1);
        chk("after_pop_outstanding", outstanding, 3);
        accept("refill", 0);
        chk("refill_outstanding", outstanding, 4);
        m_req = 2'b00;
        respond("drain0", 32'h0000_1111);
        respond("drain1", 32'h0000_2222);
        respond("drain2", 32'h0000_3333);
        respond("drain3", 32'h0000_4444);
        chk("drain_outstanding", outstanding, 0);

        // In-order response routing.
        m_req = 2'b01;
        accept("ord_m0", 0);
        m_req = 2'b10;
        accept("ord_m1", 1);
        m_req = 2'b00;
        respond("ord_r0", 32'hDEAD_BEEF);
        respond("ord_r1", 32'h1234_5678);
        chk("ord_outstanding", outstanding, 0);

        // Push and pop in the same cycle.
        m_req = 2'b01;
        accept("pp_m0", 0);
        m_req     = 2'b10;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        s_rdata   = 32'h5555_AAAA;
        settle();
        chk("pp_addr_ok", m_addr_ok, 2'b10);
        chk("pp_data_ok", m_data_ok, 64'd1 << exp_q.pop_front());
        exp_q.push_back(1);
        tick();
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        m_req     = 2'b00;
        chk("pp_outstanding", outstanding, 1);
        respond("pp_r1", 32'h6666_7777);
        chk("pp_err_orphan", err_orphan, 0);

        // Lock on a stalled grant; later master 0 request cannot steal it.
        resetn = 1'b0;
        exp_q.delete();
        tick();
        resetn = 1'b1;
        m_req  = 2'b10;
        settle();
        chk("lock_c1_s_req", s_req, 1);
        chk("lock_c1_s_addr", s_addr, 32'h1000_0004);
        chk("lock_c1_s_wr", s_wr, 1);
        chk("lock_c1_s_wstrb", s_wstrb, 4'hF);
        chk("lock_c1_s_wdata", s_wdata, 32'hB1B1_1111);
        chk("lock_c1_addr_ok", m_addr_ok, 0);
        tick();
        m_req = 2'b11;
        settle();
        chk("lock_c2_s_addr", s_addr, 32'h1000_0004);
        chk("lock_c2_s_size", s_size, 2);
        tick();
        settle();
        chk("lock_c3_s_addr", s_addr, 32'h1000_0004);
        tick();
        accept("lock_c4", 1);
        accept("lock_c5", 0);
        m_req = 2'b00;
        settle();
        chk("idle_s_addr", s_addr, 0);
        chk("idle_s_wdata", s_wdata, 0);
        tick();

        // Reset with three in flight flushes everything immediately.
        m_req = 2'b11;
        accept("pre_rst", 1);
        chk("pre_rst_outstanding", outstanding, 3);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_s_req", s_req, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_addr_ok", m_addr_ok, 0);
        exp_q.delete();
        tick();
        resetn = 1'b1;
        accept("post_rst", 0);
        m_req = 2'b00;

        // Orphan response sets a sticky error.
        respond("post_rst_r", 32'h0BAD_F00D);
        chk("pre_orphan_outstanding", outstanding, 0);
        chk("pre_orphan_err", err_orphan, 0);
        respond("orphan", 32'hFFFF_0000);
        chk("orphan_err", err_orphan, 1);
        tick();
        tick();
        chk("orphan_sticky", err_orphan, 1);
        chk("orphan_outstanding", outstanding, 0);
        resetn = 1'b0;
        #1;
        chk("orphan_cleared", err_orphan, 0);
        tick();
        resetn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
